// File: rtl/alu_stim_gen.sv
// alu_stim_gen: LFSR-driven operand/op/result source for ALU checking.
// Define ALU_STIM_CORNER_INJECT_EN to inject corner operands every 16th txn.
module alu_stim_gen #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [31:0] SEED_A  = 32'h0000_0001,
  parameter logic [31:0] SEED_B  = 32'h0000_0002,
  parameter int unsigned NUM_TXN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       op_mask,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [WIDTH:0]   result,
  output logic             add,
  output logic             sub,
  output logic             cmp,
  output logic             done,
  output logic [31:0]      txn_count
);

  localparam logic [31:0] POLY = 32'h8020_0003;

  // an all-zero seed would lock the LFSR at zero
  localparam logic [31:0] INIT_A =
    (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] INIT_B =
    (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  localparam logic [31:0] LAST_CNT = 32'(NUM_TXN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [31:0]    lfsr_a;
  logic [31:0]    lfsr_b;
  logic [31:0]    count_inc;
  logic [2:0]     mask_eff;
  logic [2:0]     op_pref;
  logic [2:0]     op_sel;
  logic [WIDTH-1:0] ld_op1;
  logic [WIDTH-1:0] ld_op2;
  logic [WIDTH:0] ext1;
  logic [WIDTH:0] ext2;
  logic [WIDTH:0] ld_res;
  logic           accept;
  logic           last;
  logic           load;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] x
  );
    lfsr_step = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  assign count_inc = txn_count + 32'd1;
  assign accept    = out_valid && out_ready;
  assign last      = (NUM_TXN != 0) &&
                     (count_inc == LAST_CNT);
  assign mask_eff  = (op_mask == 3'b000) ?
                     3'b111 : op_mask;

  // preferred op from the top two bits of lfsr_b
  always_comb begin
    op_pref = 3'b001;
    unique case (1'b1)
      lfsr_b[31]:
        op_pref = 3'b100;
      (!lfsr_b[31] && lfsr_b[30]):
        op_pref = 3'b010;
      default:
        op_pref = 3'b001;
    endcase
  end

  // fall back to highest-priority allowed op
  always_comb begin
    op_sel = op_pref;
    if ((op_pref & mask_eff) == 3'b000) begin
      unique case (1'b1)
        mask_eff[2]:
          op_sel = 3'b100;
        (!mask_eff[2] && mask_eff[1]):
          op_sel = 3'b010;
        default:
          op_sel = 3'b001;
      endcase
    end
  end

`ifdef ALU_STIM_CORNER_INJECT_EN
  logic [1:0]  ptr;
  logic [31:0] ld_count;
  logic        inject;

  // count that will sit beside the loaded txn
  assign ld_count = (state == RUN) ? count_inc : 32'd0;
  assign inject   = (ld_count[3:0] == 4'hF);

  // LFSR operands, overridden by the corner table
  always_comb begin
    ld_op1 = lfsr_a[WIDTH-1:0];
    ld_op2 = lfsr_b[WIDTH-1:0];
    if (inject) begin
      case (ptr)
        2'd0: begin
          ld_op1 = '1;
          ld_op2 = WIDTH'(1);
        end
        2'd1: begin
          ld_op1 = '0;
          ld_op2 = WIDTH'(1);
        end
        2'd2: begin
          ld_op1 = {1'b1, {(WIDTH-1){1'b0}}};
          ld_op2 = WIDTH'(1);
        end
        default: begin
          ld_op1 = '1;
          ld_op2 = '1;
        end
      endcase
    end
  end

  // corner pointer advances once per injection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (load && inject) begin
      ptr <= ptr + 2'd1;
    end
  end
`else
  assign ld_op1 = lfsr_a[WIDTH-1:0];
  assign ld_op2 = lfsr_b[WIDTH-1:0];
`endif

  assign ext1 = {1'b0, ld_op1};
  assign ext2 = {1'b0, ld_op2};

  // add keeps carry, sub/cmp keep borrow in the top bit
  assign ld_res = op_sel[2] ? (ext1 + ext2) :
                              (ext1 - ext2);

  // a new transaction is captured on this edge
  always_comb begin
    load = 1'b0;
    unique case (state)
      IDLE:    load = start;
      DONE:    load = start;
      RUN:     load = !stop && accept && !last;
      default: load = 1'b0;
    endcase
  end

  // run control: valid, done and transaction count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      txn_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            txn_count <= 32'd0;
            out_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else if (accept) begin
            txn_count <= count_inc;
            if (last) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            done      <= 1'b0;
            txn_count <= 32'd0;
            out_valid <= 1'b1;
            state     <= RUN;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // payload and LFSRs update only on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a <= INIT_A;
      lfsr_b <= INIT_B;
      op1    <= '0;
      op2    <= '0;
      result <= '0;
      add    <= 1'b0;
      sub    <= 1'b0;
      cmp    <= 1'b0;
    end else if (load) begin
      lfsr_a          <= lfsr_step(lfsr_a);
      lfsr_b          <= lfsr_step(lfsr_b);
      op1             <= ld_op1;
      op2             <= ld_op2;
      result          <= ld_res;
      {add, sub, cmp} <= op_sel;
    end
  end

endmodule

// File: tb/tb_alu_stim_gen.sv
// tb_alu_stim_gen: model-checked directed bench for alu_stim_gen.
// Two instances: 32-bit unlimited, 8-bit with NUM_TXN=4.
module tb_alu_stim_gen;

  localparam logic [31:0] POLY = 32'h8020_0003;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [2:0] op_mask;
  logic       out_ready;

  logic        v0, add0, sub0, cmp0, done0;
  logic [31:0] op1_0, op2_0, cnt0;
  logic [32:0] res_0;

  logic        v1, add1, sub1, cmp1, done1;
  logic [7:0]  op1_1, op2_1;
  logic [8:0]  res_1;
  logic [31:0] cnt1;

  int n_cmp;
  int n_fail;

  alu_stim_gen #(
    .WIDTH(32), .NUM_TXN(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stop(stop), .op_mask(op_mask),
    .out_ready(out_ready), .out_valid(v0),
    .op1(op1_0), .op2(op2_0), .result(res_0),
    .add(add0), .sub(sub0), .cmp(cmp0),
    .done(done0), .txn_count(cnt0)
  );

  alu_stim_gen #(
    .WIDTH(8), .SEED_A(32'h0),
    .SEED_B(32'hC000_0005), .NUM_TXN(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stop(stop), .op_mask(op_mask),
    .out_ready(out_ready), .out_valid(v1),
    .op1(op1_1), .op2(op2_1), .result(res_1),
    .add(add1), .sub(sub1), .cmp(cmp1),
    .done(done1), .txn_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  int          m_state [2];
  logic        m_valid [2];
  logic        m_done  [2];
  logic [31:0] m_cnt   [2];
  logic [31:0] m_la    [2];
  logic [31:0] m_lb    [2];
  longint      m_op1   [2];
  longint      m_op2   [2];
  longint      m_res   [2];
  logic [2:0]  m_flags [2];
  int          m_ptr   [2];

  function automatic int wid(int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] ntxn(int i);
    return (i == 0) ? 32'd0 : 32'd4;
  endfunction

  function automatic logic [31:0] seed_b(int i);
    return (i == 0) ? 32'h2 : 32'hC000_0005;
  endfunction

  task automatic model_load(int i);
    longint md;
    longint a;
    longint b;
    logic [2:0] pref;
    logic [2:0] msk;
    md = longint'(1) << wid(i);
    a = longint'({32'h0, m_la[i]}) % md;
    b = longint'({32'h0, m_lb[i]}) % md;
    if (m_lb[i][31]) pref = 3'b100;
    else if (m_lb[i][30]) pref = 3'b010;
    else pref = 3'b001;
    msk = (op_mask == 3'b000) ? 3'b111 : op_mask;
    if ((pref & msk) == 3'b000) begin
      if (msk[2]) pref = 3'b100;
      else if (msk[1]) pref = 3'b010;
      else pref = 3'b001;
    end
`ifdef ALU_STIM_CORNER_INJECT_EN
    if (m_cnt[i] % 16 == 15) begin
      case (m_ptr[i])
        0: begin a = md - 1; b = 1; end
        1: begin a = 0; b = 1; end
        2: begin a = md / 2; b = 1; end
        default: begin a = md - 1; b = md - 1; end
      endcase
      m_ptr[i] = (m_ptr[i] + 1) % 4;
    end
`endif
    m_op1[i] = a;
    m_op2[i] = b;
    if (pref == 3'b100) m_res[i] = a + b;
    else m_res[i] = (a - b + 2 * md) % (2 * md);
    m_flags[i] = pref;
    m_la[i] = (m_la[i] >> 1) ^
              (m_la[i][0] ? POLY : 32'h0);
    m_lb[i] = (m_lb[i] >> 1) ^
              (m_lb[i][0] ? POLY : 32'h0);
  endtask

  task automatic model_step(int i);
    if (!rst_n) begin
      m_state[i] = 0;
      m_la[i]    = 32'h1;
      m_lb[i]    = seed_b(i);
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
      m_cnt[i]   = 32'd0;
      m_op1[i]   = 0;
      m_op2[i]   = 0;
      m_res[i]   = 0;
      m_flags[i] = 3'b000;
      m_ptr[i]   = 0;
    end else begin
      case (m_state[i])
        0: if (start) begin
          m_cnt[i] = 32'd0;
          model_load(i);
          m_valid[i] = 1'b1;
          m_state[i] = 1;
        end
        1: if (stop) begin
          m_valid[i] = 1'b0;
          m_state[i] = 0;
        end else if (out_ready) begin
          m_cnt[i] = m_cnt[i] + 32'd1;
          if (ntxn(i) != 0 && m_cnt[i] == ntxn(i)) begin
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b1;
            m_state[i] = 2;
          end else begin
            model_load(i);
          end
        end
        default: if (start) begin
          m_done[i] = 1'b0;
          m_cnt[i]  = 32'd0;
          model_load(i);
          m_valid[i] = 1'b1;
          m_state[i] = 1;
        end
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // ---------------- checking ----------------
  task automatic chk(string name, int i,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h want %h",
               name, i, act, exp);
    end
  endtask

  function automatic logic [63:0] d_valid(int i);
    return (i == 0) ? 64'(v0) : 64'(v1);
  endfunction
  function automatic logic [63:0] d_done(int i);
    return (i == 0) ? 64'(done0) : 64'(done1);
  endfunction
  function automatic logic [63:0] d_cnt(int i);
    return (i == 0) ? 64'(cnt0) : 64'(cnt1);
  endfunction
  function automatic logic [63:0] d_op1(int i);
    return (i == 0) ? 64'(op1_0) : 64'(op1_1);
  endfunction
  function automatic logic [63:0] d_op2(int i);
    return (i == 0) ? 64'(op2_0) : 64'(op2_1);
  endfunction
  function automatic logic [63:0] d_res(int i);
    return (i == 0) ? 64'(res_0) : 64'(res_1);
  endfunction
  function automatic logic [63:0] d_flg(int i);
    return (i == 0) ? 64'({add0, sub0, cmp0}) :
                      64'({add1, sub1, cmp1});
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("valid", i, d_valid(i), 64'(m_valid[i]));
      chk("done", i, d_done(i), 64'(m_done[i]));
      chk("count", i, d_cnt(i), 64'(m_cnt[i]));
      if (m_valid[i]) begin
        chk("op1", i, d_op1(i), 64'(m_op1[i]));
        chk("op2", i, d_op2(i), 64'(m_op2[i]));
        chk("result", i, d_res(i), 64'(m_res[i]));
        chk("flags", i, d_flg(i), 64'(m_flags[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] masks [6];

  // ---------------- stimulus ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    masks[0] = 3'b000; masks[1] = 3'b001;
    masks[2] = 3'b010; masks[3] = 3'b011;
    masks[4] = 3'b101; masks[5] = 3'b110;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    op_mask = 3'b111; out_ready = 1'b1;
    tick(); tick();
    chk("lit_rst_valid", 0, 64'(v0), 64'd0);
    chk("lit_rst_count", 0, cnt0, 64'd0);
    chk("lit_rst_done", 0, 64'(done0), 64'd0);
    rst_n = 1'b1;
    tick();

    // default mask: cmp from seeds
    start = 1'b1; tick(); start = 1'b0;
    chk("lit_t0_op1", 0, 64'(op1_0), 64'h1);
    chk("lit_t0_op2", 0, 64'(op2_0), 64'h2);
    chk("lit_t0_flg", 0, 64'({add0, sub0, cmp0}), 64'h1);
    chk("lit_t0_res", 0, 64'(res_0), 64'h1_FFFF_FFFF);
    tick();
    chk("lit_t1_op1", 0, 64'(op1_0), 64'h8020_0003);
    chk("lit_t1_op2", 0, 64'(op2_0), 64'h1);
    chk("lit_t1_res", 0, 64'(res_0), 64'h0_8020_0002);
    chk("lit_t1_cnt", 0, cnt0, 64'd1);
    tick(); tick(); tick();
    chk("lit_n4_done", 1, 64'(done1), 64'd1);
    chk("lit_n4_cnt", 1, cnt1, 64'd4);
    chk("lit_n4_valid", 1, 64'(v1), 64'd0);
    tick(); tick();

    // stop beats a simultaneous accept
    stop = 1'b1; tick(); stop = 1'b0;
    chk("lit_stop_valid", 0, 64'(v0), 64'd0);
    chk("lit_stop_cnt", 0, cnt0, 64'd6);
    tick();

    // async reset in the middle of a run
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", 0, 64'(v0), 64'd0);
    chk("lit_arst_op1", 0, 64'(op1_0), 64'd0);
    chk("lit_arst_res", 0, 64'(res_0), 64'd0);
    chk("lit_arst_cnt", 0, cnt0, 64'd0);
    chk("lit_arst_flg", 0, 64'({add0, sub0, cmp0}), 64'd0);
    chk("lit_arst_done1", 1, 64'(done1), 64'd0);
    tick();
    rst_n = 1'b1; op_mask = 3'b100;
    tick();

    // add-only mask
    start = 1'b1; tick(); start = 1'b0;
    chk("lit_add_op1", 0, 64'(op1_0), 64'h1);
    chk("lit_add_op2", 0, 64'(op2_0), 64'h2);
    chk("lit_add_flg", 0, 64'({add0, sub0, cmp0}), 64'h4);
    chk("lit_add_res", 0, 64'(res_0), 64'h3);
    tick();
    chk("lit_add1_res", 0, 64'(res_0), 64'h0_8020_0004);

    // backpressure and mask changes
    for (int k = 0; k < 24; k++) begin
      out_ready = (k % 2 == 0) ? 1'b0 : 1'b1;
      op_mask = masks[k % 6];
      start = (k == 8 || k == 17) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("lit_hold_valid", 0, 64'(v0), 64'd1);

    // long run to reach the 16th and 32nd txn
    rst_n = 1'b0; tick();
    rst_n = 1'b1; op_mask = 3'b100; out_ready = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    chk("lit_c15_cnt", 0, cnt0, 64'd15);
`ifdef ALU_STIM_CORNER_INJECT_EN
    chk("lit_c16_op1", 0, 64'(op1_0), 64'hFFFF_FFFF);
    chk("lit_c16_op2", 0, 64'(op2_0), 64'h1);
    chk("lit_c16_res", 0, 64'(res_0), 64'h1_0000_0000);
`endif
    repeat (16) tick();
    chk("lit_c31_cnt", 0, cnt0, 64'd31);
`ifdef ALU_STIM_CORNER_INJECT_EN
    chk("lit_c32_op1", 0, 64'(op1_0), 64'h0);
    chk("lit_c32_op2", 0, 64'(op2_0), 64'h1);
    chk("lit_c32_res", 0, 64'(res_0), 64'h1);
`endif
    op_mask = 3'b011;
    repeat (4) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
